// File: rtl/dmem_ctrl_fsm_pkg.sv
// Shared types for the data-memory controller: FSM state encoding and the
// latched dcache request that drives the dcache port.
package dmem_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    LOAD_WAIT  = 2'd2,
    DRAIN      = 2'd3
  } dmem_fsm_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_ctrl_fsm.sv
// Single-port dcache controller serving the store RS (priority) and load RS,
// one transaction at a time, with silent draining of flushed accesses.
module dmem_ctrl_fsm
  import dmem_ctrl_fsm_pkg::*;
#(
  parameter int ROB_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 move_flush,
  input  logic                 dmem_w_rqst,
  input  logic [31:0]          store_addr,
  input  logic [3:0]           store_wmask,
  input  logic [31:0]          store_wdata,
  output logic                 store_rs_pop,
  input  logic                 dmem_r_rqst,
  input  logic [31:0]          load_addr,
  input  logic [3:0]           load_rmask,
  input  logic [ROB_DEPTH-1:0] load_rob,
  output logic                 load_accept,
  output logic                 load_resp_valid,
  output logic [ROB_DEPTH-1:0] load_resp_rob,
  output logic [31:0]          load_resp_rdata,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp
);

  dmem_fsm_state_t      state_q, state_d;
  dmem_req_t            req_q, req_d;
  logic [ROB_DEPTH-1:0] rob_q, rob_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      rob_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rob_q   <= rob_d;
    end
  end

  // NOTE: every signal gets a hold default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rob_d   = rob_q;
    unique case (state_q)
      IDLE: begin
        if (!move_flush) begin
          if (dmem_w_rqst) begin
            state_d = STORE_WAIT;
            req_d   = '{addr:  word_align(store_addr),
                        rmask: 4'b0000,
                        wmask: store_wmask,
                        wdata: store_wdata};
            rob_d   = '0;
          end else if (dmem_r_rqst) begin
            state_d = LOAD_WAIT;
            req_d   = '{addr:  word_align(load_addr),
                        rmask: load_rmask,
                        wmask: 4'b0000,
                        wdata: 32'h0};
            rob_d   = load_rob;
          end
        end
      end
      STORE_WAIT, LOAD_WAIT: begin
        if (dmem_resp) begin
          state_d = IDLE;
          req_d   = '0;
          rob_d   = '0;
        end else if (move_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_resp) begin
          state_d = IDLE;
          req_d   = '0;
          rob_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
        rob_d   = '0;
      end
    endcase
  end

  // Pulses are qualified by rst_n so requests held during reset stay invisible.
  always_comb begin
    store_rs_pop    = rst_n && (state_q == STORE_WAIT) && dmem_resp && !move_flush;
    load_accept     = rst_n && (state_q == IDLE) && !move_flush
                      && !dmem_w_rqst && dmem_r_rqst;
    load_resp_valid = rst_n && (state_q == LOAD_WAIT) && dmem_resp && !move_flush;
    load_resp_rob   = load_resp_valid ? rob_q : '0;
    load_resp_rdata = load_resp_valid ? dmem_rdata : 32'h0;
    dmem_addr       = req_q.addr;
    dmem_rmask      = req_q.rmask;
    dmem_wmask      = req_q.wmask;
    dmem_wdata      = req_q.wdata;
  end

endmodule
